// File: rtl/fxp_pkg.sv
// rtl/fxp_pkg.sv - shared constants and code-limit helpers for the fixed-point multiplier
package fxp_pkg;

    localparam int ROUND_TRUNC   = 0;
    localparam int ROUND_HALF_UP = 1;
    localparam int SAT_WRAP      = 0;
    localparam int SAT_CLAMP     = 1;

    // Returned in 64 bits so callers can size-cast to any supported width
    function automatic logic signed [63:0] max_code(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] min_code(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/fxp_mult_pipe_if.sv
// rtl/fxp_mult_pipe_if.sv - operand/result handshake bundle for the fixed-point multiplier
interface fxp_mult_pipe_if #(
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] A_in;
    logic [DATA_W-1:0] B_in;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out;
    logic              overflow_flag;
    logic              underflow_flag;
    logic              zero_loss_flag;

    modport master (
        output in_valid, A_in, B_in, out_ready,
        input  in_ready, out_valid, out, overflow_flag, underflow_flag, zero_loss_flag
    );

    modport slave (
        input  in_valid, A_in, B_in, out_ready,
        output in_ready, out_valid, out, overflow_flag, underflow_flag, zero_loss_flag
    );
endinterface

// File: rtl/fxp_round_sat.sv
// rtl/fxp_round_sat.sv - combinational rounding, range check and saturation of a full product
module fxp_round_sat
    import fxp_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int FRAC_W   = 14,
    parameter int ROUND_EN = ROUND_HALF_UP,
    parameter int SAT_EN   = SAT_CLAMP
) (
    input  logic signed [2*DATA_W-1:0] prod_i,
    output logic        [DATA_W-1:0]   res_o,
    output logic                       ovf_o,
    output logic                       udf_o,
    output logic                       zloss_o
);

    // One guard bit above the product so the rounding add can never wrap
    localparam int PW = 2*DATA_W + 1;
    localparam logic signed [PW-1:0] RND_K =
        (ROUND_EN == ROUND_HALF_UP) ? (PW'(1) << (FRAC_W - 1)) : '0;
    localparam logic signed [PW-1:0] MAX_V = PW'(max_code(DATA_W));
    localparam logic signed [PW-1:0] MIN_V = PW'(min_code(DATA_W));
    localparam logic [DATA_W-1:0]    MAX_C = DATA_W'(max_code(DATA_W));
    localparam logic [DATA_W-1:0]    MIN_C = DATA_W'(min_code(DATA_W));

    logic signed [PW-1:0] ext;
    logic signed [PW-1:0] rnd;
    logic signed [PW-1:0] sh;

    always_comb begin
        ext   = PW'(prod_i);
        rnd   = ext + RND_K;
        sh    = rnd >>> FRAC_W;
        ovf_o = (sh > MAX_V);
        udf_o = (sh < MIN_V);
        if ((SAT_EN == SAT_CLAMP) && ovf_o) begin
            res_o = MAX_C;
        end else if ((SAT_EN == SAT_CLAMP) && udf_o) begin
            res_o = MIN_C;
        end else begin
            res_o = sh[DATA_W-1:0];
        end
        zloss_o = (prod_i != '0) && (res_o == '0);
    end

endmodule

// File: rtl/fxp_mult_pipe.sv
// rtl/fxp_mult_pipe.sv - three-stage signed fixed-point multiplier with backpressure and statistics
module fxp_mult_pipe
    import fxp_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int FRAC_W   = 14,
    parameter int ROUND_EN = ROUND_HALF_UP,
    parameter int SAT_EN   = SAT_CLAMP,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    fxp_mult_pipe_if.slave   io,
    input  logic             stat_clr,
    output logic             ovf_sticky,
    output logic             udf_sticky,
    output logic [CNT_W-1:0] sat_count
);

    localparam int PW2 = 2*DATA_W;

    logic                     adv;
    logic                     hs;
    logic signed [DATA_W-1:0] a_q, b_q;
    logic signed [PW2-1:0]    prod_d, prod_q;
    logic                     v1_q, v2_q, v3_q;
    logic [DATA_W-1:0]        res_d, out_q;
    logic                     ovf_d, udf_d, zl_d;
    logic                     ovf_q, udf_q, zl_q;
    logic                     ovf_sticky_q, udf_sticky_q;
    logic [CNT_W-1:0]         cnt_d, cnt_q;

    // The whole pipe moves as one; a held output stalls every stage behind it
    assign adv               = io.out_ready | ~v3_q;
    assign hs                = v3_q & io.out_ready;
    assign io.in_ready       = adv;
    assign io.out_valid      = v3_q;
    assign io.out            = out_q;
    assign io.overflow_flag  = ovf_q;
    assign io.underflow_flag = udf_q;
    assign io.zero_loss_flag = zl_q;
    assign ovf_sticky        = ovf_sticky_q;
    assign udf_sticky        = udf_sticky_q;
    assign sat_count         = cnt_q;

    assign prod_d = PW2'(a_q) * PW2'(b_q);

    fxp_round_sat #(
        .DATA_W   (DATA_W),
        .FRAC_W   (FRAC_W),
        .ROUND_EN (ROUND_EN),
        .SAT_EN   (SAT_EN)
    ) u_round_sat (
        .prod_i  (prod_q),
        .res_o   (res_d),
        .ovf_o   (ovf_d),
        .udf_o   (udf_d),
        .zloss_o (zl_d)
    );

    always_ff @(posedge clk) begin
        if (adv) begin
            a_q    <= io.A_in;
            b_q    <= io.B_in;
            prod_q <= prod_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            out_q <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
            zl_q  <= 1'b0;
        end else if (adv) begin
            v1_q  <= io.in_valid;
            v2_q  <= v1_q;
            v3_q  <= v2_q;
            out_q <= res_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
            zl_q  <= zl_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stat_clr) begin
            cnt_d = '0;
        end else if (hs && (ovf_q || udf_q) && (SAT_EN == SAT_CLAMP) && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky_q <= 1'b0;
            udf_sticky_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (stat_clr) begin
                ovf_sticky_q <= 1'b0;
                udf_sticky_q <= 1'b0;
            end else begin
                if (hs && ovf_q) ovf_sticky_q <= 1'b1;
                if (hs && udf_q) udf_sticky_q <= 1'b1;
            end
        end
    end

endmodule

// File: doc/fxp_mult_pipe.md
FXP_MULT_PIPE -- requirements
Module: fxp_mult_pipe

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, operand and result width in bits.
REQ-002 The block SHALL have parameter FRAC_W, default 14, fractional bits of operands and result (Q(DATA_W-FRAC_W).FRAC_W).
REQ-003 The block SHALL have parameter ROUND_EN, default 1, where 1 = round-half-up and 0 = truncate (floor).
REQ-004 The block SHALL have parameter SAT_EN, default 1, where 1 = saturate on range exceed and 0 = wrap (keep low DATA_W bits).
REQ-005 The block SHALL have parameter CNT_W, default 16, saturation-event counter width.
REQ-006 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-007 The block SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-008 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-009 The block SHALL have port in_valid, input, 1 bit, operand pair valid.
REQ-010 The block SHALL have port in_ready, output, 1 bit, block accepts operands.
REQ-011 The block SHALL have ports A_in and B_in, input, DATA_W bits each, signed operands.
REQ-012 The block SHALL have port out_valid, output, 1 bit, result valid.
REQ-013 The block SHALL have port out_ready, input, 1 bit, consumer accepts result.
REQ-014 The block SHALL have port out, output, DATA_W bits, signed result.
REQ-015 The block SHALL have port overflow_flag, output, 1 bit, result exceeded max positive; qualified by out_valid.
REQ-016 The block SHALL have port underflow_flag, output, 1 bit, result below min negative; qualified by out_valid.
REQ-017 The block SHALL have port zero_loss_flag, output, 1 bit, exact product nonzero but result is zero; qualified by out_valid.
REQ-018 The block SHALL have port stat_clr, input, 1 bit, synchronous clear of sticky flags and counter.
REQ-019 The block SHALL have ports ovf_sticky and udf_sticky, output, 1 bit each, sticky overflow and underflow.
REQ-020 The block SHALL have port sat_count, output, CNT_W bits, number of saturated results.

Function
REQ-021 The pipeline SHALL be three stages: S1 registers operands, S2 registers the full 2*DATA_W signed product, S3 registers the rounded, range-checked result.
REQ-022 The pipeline SHALL advance only when adv = out_ready OR NOT out_valid, and in_ready SHALL equal adv combinationally.
REQ-023 A transfer SHALL occur on a cycle where in_valid AND in_ready are both high; the result SHALL appear with out_valid high 3 cycles later if never stalled.
REQ-024 When adv=0, all stage data and valid bits SHALL hold, and out and flags SHALL stay stable while out_valid=1.
REQ-025 Bubbles (invalid stages) SHALL propagate, and results SHALL be produced in acceptance order with none dropped or duplicated.
REQ-026 Rounding SHALL be: ROUND_EN=1 adds 2^(FRAC_W-1) to the product in 2*DATA_W+1 bits, then arithmetic shift right by FRAC_W; ROUND_EN=0 uses the arithmetic shift only.
REQ-027 Range checking SHALL set overflow_flag when the shifted value > 2^(DATA_W-1)-1, and underflow_flag when it < -2^(DATA_W-1); at most one of the two SHALL be set.
REQ-028 With SAT_EN=1, out SHALL be the max or min code on overflow or underflow respectively; with SAT_EN=0, out SHALL be the low DATA_W bits of the shifted value and the flags SHALL still be reported.
REQ-029 zero_loss_flag SHALL be 1 when the S2 product is nonzero and out is 0.
REQ-030 The sticky flags SHALL set on an output handshake (out_valid AND out_ready) carrying the respective flag.
REQ-031 sat_count SHALL increment on each such handshake with overflow or underflow set and SAT_EN=1, and SHALL saturate at all-ones without wrapping.
REQ-032 stat_clr SHALL have priority over a simultaneous set or increment.
REQ-033 A DATA_W=8..32 range SHALL be supported, with 0 < FRAC_W < DATA_W.

Reset
REQ-034 On rst_n low, all valid bits, out, all flags, sticky flags and sat_count SHALL go to 0 asynchronously.
REQ-035 Data registers other than out SHALL be allowed to be non-reset.
REQ-036 Reset asserted mid-operation SHALL discard all in-flight results.
REQ-037 After rst_n deasserts, in_ready SHALL be 1 on the first clock.

Structure
REQ-038 Package fxp_pkg SHALL hold the round-mode and saturate-mode constants, plus max/min code functions parameterised by width.
REQ-039 Sub-module fxp_round_sat (combinational: product in; out and flags out) SHALL be instantiated in S3.

Verification
REQ-040 Defaults, 0x4000 x 0x4000 (1.0x1.0), out_ready=1 -> out=0x4000, no flags, 3 cycles after accept.
REQ-041 0x6000 x 0x6000 (1.5x1.5) -> out=0x7FFF, overflow_flag=1, sat_count=1; 0x8000 x 0x6000 -> out=0x8000, underflow_flag=1, sat_count=2.
REQ-042 0x0001 x 0x2000 -> ROUND_EN=1 gives out=0x0001, ROUND_EN=0 gives out=0x0000 with zero_loss_flag=1.
REQ-043 Stream 10 back-to-back pairs with out_ready low on cycles 4-7 -> in_ready low in the same cycles, 10 results in order, held stable while stalled.
REQ-044 rst_n pulsed low with 2 results in flight -> out_valid=0 immediately, no stale result after release.
REQ-045 stat_clr asserted in the same cycle as a saturating handshake -> sticky flags=0 and sat_count=0 next cycle.
